// File: rtl/arf_mp_if.sv
// arf_mp_if: bundles the read, writeback and checkpoint signals of the multi-port
// architectural register file.
//   master : drives rd_en/rd_idx, wb_en/wb_idx/wb_data and ckpt_save/ckpt_restore;
//            samples rd_data, ckpt_valid and wb_conflict.
//   slave  : the register file side (arf_mp).
// Port p of a packed vector sits at [p*IDX_W +: IDX_W] or [p*DATA_W +: DATA_W].
interface arf_mp_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned NREG   = 32,
   parameter int unsigned NRD    = 8,
   parameter int unsigned NWR    = 4
);
   localparam int unsigned IDX_W = $clog2(NREG);

   logic [NRD-1:0]        rd_en;
   logic [NRD*IDX_W-1:0]  rd_idx;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NWR-1:0]        wb_en;
   logic [NWR*IDX_W-1:0]  wb_idx;
   logic [NWR*DATA_W-1:0] wb_data;
   logic                  ckpt_save;
   logic                  ckpt_restore;
   logic                  ckpt_valid;
   logic                  wb_conflict;

   modport master (
      output rd_en, rd_idx, wb_en, wb_idx, wb_data, ckpt_save, ckpt_restore,
      input  rd_data, ckpt_valid, wb_conflict
   );

   modport slave (
      input  rd_en, rd_idx, wb_en, wb_idx, wb_data, ckpt_save, ckpt_restore,
      output rd_data, ckpt_valid, wb_conflict
   );
endinterface

// File: rtl/arf_mp.sv
// arf_mp: parametrised multi-port architectural register file with hardwired zero
// register, fixed-priority write conflict resolution (highest port wins), a registered
// conflict flag and a single-slot checkpoint for one-cycle flush recovery.
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : synchronous active-high reset (clears arrays, ckpt_valid, wb_conflict)
//   io_bus : arf_mp_if.slave -- combinational reads, writeback ports, checkpoint control
// Build option: define ARF_BYPASS_EN to forward same-cycle write data to the read ports.
module arf_mp #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned NREG   = 32,
   parameter int unsigned NRD    = 8,
   parameter int unsigned NWR    = 4
) (
   input logic      i_clk,
   input logic      i_rst,
   arf_mp_if.slave  io_bus
);
   localparam int unsigned IDX_W = $clog2(NREG);

   logic [DATA_W-1:0]     r_main   [NREG];
   logic [DATA_W-1:0]     r_shadow [NREG];
   logic                  r_ckpt_valid;
   logic                  r_wb_conflict;

   logic [DATA_W-1:0]     w_main_nxt [NREG];
   logic                  w_restore;
   logic                  w_save;
   logic                  w_conflict;
   logic [NRD*DATA_W-1:0] w_rd_data;

   // A restore only counts with a live snapshot; it then beats any same-cycle save.
   assign w_restore = io_bus.ckpt_restore & r_ckpt_valid;
   assign w_save    = io_bus.ckpt_save & ~w_restore;

   // Main array after this cycle's writes; ascending port order gives the highest port
   // the last word. Index 0 is skipped so entry 0 stays zero from reset.
   always_comb begin
      w_main_nxt = r_main;
      for (int w = 0; w < NWR; w++) begin
         if (io_bus.wb_en[w] && (io_bus.wb_idx[w*IDX_W +: IDX_W] != '0)) begin
            w_main_nxt[io_bus.wb_idx[w*IDX_W +: IDX_W]] = io_bus.wb_data[w*DATA_W +: DATA_W];
         end
      end
   end

   // Any pair of enabled ports hitting the same nonzero index.
   always_comb begin
      w_conflict = 1'b0;
      for (int a = 0; a < NWR; a++) begin
         for (int b = a + 1; b < NWR; b++) begin
            if (io_bus.wb_en[a] && io_bus.wb_en[b] &&
                (io_bus.wb_idx[a*IDX_W +: IDX_W] == io_bus.wb_idx[b*IDX_W +: IDX_W]) &&
                (io_bus.wb_idx[a*IDX_W +: IDX_W] != '0)) begin
               w_conflict = 1'b1;
            end
         end
      end
   end

   // Combinational reads; disabled ports and index 0 return zero.
   always_comb begin
      w_rd_data = '0;
      for (int p = 0; p < NRD; p++) begin
         if (io_bus.rd_en[p] && (io_bus.rd_idx[p*IDX_W +: IDX_W] != '0)) begin
            w_rd_data[p*DATA_W +: DATA_W] = r_main[io_bus.rd_idx[p*IDX_W +: IDX_W]];
`ifdef ARF_BYPASS_EN
            // Forwarding is off during a restore: the writes are about to be discarded.
            if (!w_restore) begin
               for (int w = 0; w < NWR; w++) begin
                  if (io_bus.wb_en[w] &&
                      (io_bus.wb_idx[w*IDX_W +: IDX_W] == io_bus.rd_idx[p*IDX_W +: IDX_W])) begin
                     w_rd_data[p*DATA_W +: DATA_W] = io_bus.wb_data[w*DATA_W +: DATA_W];
                  end
               end
            end
`endif
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_main[i]   <= '0;
            r_shadow[i] <= '0;
         end
         r_ckpt_valid  <= 1'b0;
         r_wb_conflict <= 1'b0;
      end else if (w_restore) begin
         r_main        <= r_shadow;
         r_ckpt_valid  <= 1'b0;
         r_wb_conflict <= 1'b0;
      end else begin
         r_main        <= w_main_nxt;
         r_wb_conflict <= w_conflict;
         if (w_save) begin
            // Snapshot includes this cycle's writes.
            r_shadow     <= w_main_nxt;
            r_ckpt_valid <= 1'b1;
         end
      end
   end

   assign io_bus.rd_data     = w_rd_data;
   assign io_bus.ckpt_valid  = r_ckpt_valid;
   assign io_bus.wb_conflict = r_wb_conflict;

endmodule

// File: tb/tb_arf_mp.sv
// tb_arf_mp: self-checking bench for arf_mp. Directed checks follow the block's
// behaviour list; a randomized phase compares every read port and both status flags
// against a behavioural model of the register file kept in plain arrays.
module tb_arf_mp;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned NREG   = 32;
   localparam int unsigned NRD    = 8;
   localparam int unsigned NWR    = 4;
   localparam int unsigned IDX_W  = $clog2(NREG);

   logic clk;
   logic rst;

   arf_mp_if #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

   arf_mp #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD), .NWR(NWR)) u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   logic [DATA_W-1:0] m_main   [NREG];
   logic [DATA_W-1:0] m_shadow [NREG];
   logic              m_valid;
   logic              m_conflict;

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] rd(input int p);
      return bus.rd_data[p*DATA_W +: DATA_W];
   endfunction

   task automatic clear_inputs();
      bus.rd_en        = '0;
      bus.rd_idx       = '0;
      bus.wb_en        = '0;
      bus.wb_idx       = '0;
      bus.wb_data      = '0;
      bus.ckpt_save    = 1'b0;
      bus.ckpt_restore = 1'b0;
   endtask

   task automatic set_wr(input int port, input int idx, input logic [DATA_W-1:0] d);
      bus.wb_en[port]                    = 1'b1;
      bus.wb_idx[port*IDX_W +: IDX_W]    = IDX_W'(idx);
      bus.wb_data[port*DATA_W +: DATA_W] = d;
   endtask

   task automatic set_rd(input int port, input int idx);
      bus.rd_en[port]                 = 1'b1;
      bus.rd_idx[port*IDX_W +: IDX_W] = IDX_W'(idx);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_main[i]   = '0;
         m_shadow[i] = '0;
      end
      m_valid    = 1'b0;
      m_conflict = 1'b0;
   endtask

   // Expected read value for port p given current inputs and model state.
   function automatic logic [DATA_W-1:0] model_read(input int p);
      int idx;
      logic [DATA_W-1:0] v;
      idx = int'(bus.rd_idx[p*IDX_W +: IDX_W]);
      if (!bus.rd_en[p] || idx == 0) return '0;
      v = m_main[idx];
`ifdef ARF_BYPASS_EN
      if (!(bus.ckpt_restore && m_valid)) begin
         for (int w = 0; w < NWR; w++)
            if (bus.wb_en[w] && int'(bus.wb_idx[w*IDX_W +: IDX_W]) == idx)
               v = bus.wb_data[w*DATA_W +: DATA_W];
      end
`endif
      return v;
   endfunction

   task automatic model_step();
      int hits [NREG];
      int idx;
      if (rst) begin
         model_reset();
         return;
      end
      if (bus.ckpt_restore && m_valid) begin
         m_main     = m_shadow;
         m_valid    = 1'b0;
         m_conflict = 1'b0;
         return;
      end
      for (int i = 0; i < NREG; i++) hits[i] = 0;
      for (int w = 0; w < NWR; w++) begin
         idx = int'(bus.wb_idx[w*IDX_W +: IDX_W]);
         if (bus.wb_en[w] && idx != 0) begin
            m_main[idx] = bus.wb_data[w*DATA_W +: DATA_W];
            hits[idx]++;
         end
      end
      m_conflict = 1'b0;
      for (int i = 1; i < NREG; i++) if (hits[i] >= 2) m_conflict = 1'b1;
      if (bus.ckpt_save) begin
         m_shadow = m_main;
         m_valid  = 1'b1;
      end
   endtask

   // Check reads against the model, clock once, then check the status flags.
   task automatic tick();
      #1;
      for (int p = 0; p < NRD; p++) check_eq("model_rd", rd(p), model_read(p));
      model_step();
      @(posedge clk);
      #1;
      check_eq("model_ckpt_valid", {63'd0, bus.ckpt_valid}, {63'd0, m_valid});
      check_eq("model_wb_conflict", {63'd0, bus.wb_conflict}, {63'd0, m_conflict});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      // Reset state: every index on every port reads zero
      for (int b = 0; b < NREG / NRD; b++) begin
         for (int p = 0; p < NRD; p++) set_rd(p, b * NRD + p);
         #1;
         for (int p = 0; p < NRD; p++) check_eq("reset_rd", rd(p), '0);
      end
      check_eq("reset_ckpt_valid", {63'd0, bus.ckpt_valid}, '0);
      check_eq("reset_wb_conflict", {63'd0, bus.wb_conflict}, '0);
      clear_inputs();

      // Simple write and read-back
      set_wr(1, 5, 64'hDEAD);
      set_rd(0, 5);
      tick();
      check_eq("wr_idx5", rd(0), 64'hDEAD);
      clear_inputs();

      // Writes to register 0 are discarded
      set_wr(1, 0, 64'h1234);
      set_rd(1, 0);
      tick();
      check_eq("wr_idx0", rd(1), '0);
      check_eq("idx0_no_conflict", {63'd0, bus.wb_conflict}, '0);
      clear_inputs();

      // Same-index conflict: port 3 beats port 0, flag pulses once
      set_wr(0, 7, 64'h11);
      set_wr(3, 7, 64'h33);
      set_rd(2, 7);
      tick();
      check_eq("conflict_data", rd(2), 64'h33);
      check_eq("conflict_flag", {63'd0, bus.wb_conflict}, 64'd1);
      clear_inputs();
      tick();
      check_eq("conflict_clear", {63'd0, bus.wb_conflict}, '0);

      // Checkpoint save includes same-cycle write; restore discards writes
      set_wr(0, 2, 64'hA);
      bus.ckpt_save = 1'b1;
      tick();
      check_eq("save_valid", {63'd0, bus.ckpt_valid}, 64'd1);
      clear_inputs();
      set_wr(0, 2, 64'hB);
      tick();
      clear_inputs();
      bus.ckpt_restore = 1'b1;
      set_wr(0, 4, 64'hC);
      tick();
      clear_inputs();
      set_rd(0, 2);
      set_rd(1, 4);
      #1;
      check_eq("restore_idx2", rd(0), 64'hA);
      check_eq("restore_idx4", rd(1), '0);
      check_eq("restore_valid", {63'd0, bus.ckpt_valid}, '0);
      tick();
      clear_inputs();

      // Save+restore together: restore wins while valid, save honoured otherwise
      bus.ckpt_save = 1'b1;
      tick();
      clear_inputs();
      set_wr(2, 3, 64'h77);
      tick();
      clear_inputs();
      bus.ckpt_save    = 1'b1;
      bus.ckpt_restore = 1'b1;
      tick();
      clear_inputs();
      set_rd(3, 3);
      #1;
      check_eq("sr_restore_idx3", rd(3), '0);
      check_eq("sr_restore_valid", {63'd0, bus.ckpt_valid}, '0);
      bus.ckpt_save    = 1'b1;
      bus.ckpt_restore = 1'b1;
      tick();
      check_eq("sr_save_valid", {63'd0, bus.ckpt_valid}, 64'd1);
      clear_inputs();

      // Same-cycle read of a write in flight
      set_wr(0, 9, 64'h44);
      tick();
      clear_inputs();
      set_wr(2, 9, 64'h55);
      set_rd(6, 9);
      #1;
`ifdef ARF_BYPASS_EN
      check_eq("bypass_rd", rd(6), 64'h55);
`else
      check_eq("no_bypass_rd", rd(6), 64'h44);
`endif
      tick();
      clear_inputs();

      // Mid-sequence reset wipes everything, including a pending conflict
      set_wr(0, 12, 64'h1);
      set_wr(1, 12, 64'h2);
      bus.ckpt_save = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_inputs();
      check_eq("rst_ckpt_valid", {63'd0, bus.ckpt_valid}, '0);
      check_eq("rst_wb_conflict", {63'd0, bus.wb_conflict}, '0);
      for (int b = 0; b < NREG / NRD; b++) begin
         for (int p = 0; p < NRD; p++) set_rd(p, b * NRD + p);
         #1;
         for (int p = 0; p < NRD; p++) check_eq("rst_rd", rd(p), '0);
      end
      clear_inputs();

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         bus.rd_en = NRD'($urandom);
         for (int p = 0; p < NRD; p++)
            bus.rd_idx[p*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, NREG - 1));
         bus.wb_en = NWR'($urandom);
         for (int w = 0; w < NWR; w++) begin
            if ($urandom_range(0, 1) == 0)
               bus.wb_idx[w*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 7));
            else
               bus.wb_idx[w*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, NREG - 1));
            bus.wb_data[w*DATA_W +: DATA_W] = {$urandom, $urandom};
         end
         bus.ckpt_save    = ($urandom_range(0, 7) == 0);
         bus.ckpt_restore = ($urandom_range(0, 7) == 0);
         rst              = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
